qspi_crypt_pipeline: RTL and testbench

//  Nibble-wide streaming XOR cipher: parallelizer + NUM_ENC encrypter lanes + collector.

---
 rtl/qspi_crypt_pipeline.sv | 279 +++++++++++++++++++++++++++
 tb/tb_qspi_crypt_pipeline.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_crypt_pipeline.sv
// qspi_crypt_pipeline: nibble-wide streaming XOR cipher.
// A 32-bit key is loaded after a prog pulse. The nibble stream is then packed into words,
// dealt round-robin to NUM_ENC encrypter lanes, and re-serialised in input order.
// The build-time macro KEY_ROTATION_EN turns on per-word left rotation of the key.
// Without it, every word is XORed with the unrotated key.
module qspi_crypt_pipeline #(
  parameter int unsigned NUM_ENC = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ROT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog,
  input  logic [3:0] in_data,
  input  logic       in_sending,
  output logic       in_ready,
  output logic [3:0] out_data,
  output logic       out_sending,
  input  logic       out_ready
);

  localparam int unsigned Nibs  = WIDTH / 4;
  localparam int unsigned Bytes = WIDTH / 8;
  localparam int unsigned CntW  = $clog2(Nibs + 1);
  localparam int unsigned ByteW = $clog2(Bytes + 1);
  localparam int unsigned PtrW  = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StKey   = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;  // partial word waiting for a free lane

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v,
                                             input logic [ROT_W-1:0] r);
    logic [2*WIDTH-1:0] d;
    d = {v, v} << r;
    return d[2*WIDTH-1 -: WIDTH];
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NUM_ENC - 1)) ? '0 : p + 1'b1;
  endfunction

  // Input side
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d, asm_ins;
  logic [CntW-1:0]  nib_cnt_q, nib_cnt_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             key_load;
  logic [PtrW-1:0]  deal_ptr_q, deal_ptr_d;
  logic             take;
  logic             nib_last;

  // Dispatch bus into the lane selected by deal_ptr
  logic             dispatch;
  logic [WIDTH-1:0] disp_word;
  logic [ByteW-1:0] disp_bytes;
  logic [ROT_W-1:0] rot_sel;

  // Lanes
  logic             lane_full_q  [NUM_ENC];
  logic             lane_full_d  [NUM_ENC];
  logic             lane_done_q  [NUM_ENC];
  logic             lane_done_d  [NUM_ENC];
  logic [WIDTH-1:0] lane_word_q  [NUM_ENC];
  logic [WIDTH-1:0] lane_word_d  [NUM_ENC];
  logic [ROT_W-1:0] lane_rot_q   [NUM_ENC];
  logic [ROT_W-1:0] lane_rot_d   [NUM_ENC];
  logic [ByteW-1:0] lane_bytes_q [NUM_ENC];
  logic [ByteW-1:0] lane_bytes_d [NUM_ENC];
  logic             lane_free;

  // Collector
  logic [PtrW-1:0]  drain_ptr_q, drain_ptr_d;
  logic [WIDTH-1:0] coll_sr_q, coll_sr_d;
  logic [CntW-1:0]  coll_left_q, coll_left_d;
  logic             coll_free;
  logic             cap_fire;

  // Collector can take a new word when empty or when its last nibble leaves this cycle.
  always_comb begin
    coll_free = (coll_left_q == '0) || ((coll_left_q == CntW'(1)) && out_ready);
    cap_fire  = coll_free && lane_done_q[drain_ptr_q];
    // A lane being captured this cycle can be refilled in the same cycle.
    lane_free = !lane_full_q[deal_ptr_q] || (cap_fire && (drain_ptr_q == deal_ptr_q));
    take      = in_sending && in_ready;
    nib_last  = (nib_cnt_q == CntW'(Nibs - 1));
    asm_ins   = asm_q;
    asm_ins[(Nibs - 1 - int'(nib_cnt_q)) * 4 +: 4] = in_data;
  end

  // Input FSM: key loading, word packing and dispatch of full or partial words.
  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    nib_cnt_d  = nib_cnt_q;
    key_load   = 1'b0;
    dispatch   = 1'b0;
    disp_word  = asm_q;
    disp_bytes = ByteW'(Bytes);
    in_ready   = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = !prog && lane_free;
        if (prog) begin
          state_d   = StKey;
          asm_d     = '0;
          nib_cnt_d = '0;
        end else if (take) begin
          asm_d     = asm_ins;
          nib_cnt_d = nib_cnt_q + 1'b1;
          state_d   = StData;
        end
      end
      StKey: begin
        in_ready = 1'b1;
        if (take) begin
          if (nib_last) begin
            key_load  = 1'b1;
            asm_d     = '0;
            nib_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            asm_d     = asm_ins;
            nib_cnt_d = nib_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        in_ready = lane_free;
        if (in_sending) begin
          if (take) begin
            if (nib_last) begin
              dispatch  = 1'b1;
              disp_word = asm_ins;
              asm_d     = '0;
              nib_cnt_d = '0;
            end else begin
              asm_d     = asm_ins;
              nib_cnt_d = nib_cnt_q + 1'b1;
            end
          end
        end else if (nib_cnt_q == '0) begin
          state_d = StIdle;
        end else if (lane_free) begin
          // Burst ended mid-word: ship it with the count of bytes actually seen.
          dispatch   = 1'b1;
          disp_bytes = ByteW'((nib_cnt_q + CntW'(1)) >> 1);
          asm_d      = '0;
          nib_cnt_d  = '0;
          state_d    = StIdle;
        end else begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        in_ready = 1'b0;
        if (lane_free) begin
          dispatch   = 1'b1;
          disp_bytes = ByteW'((nib_cnt_q + CntW'(1)) >> 1);
          asm_d      = '0;
          nib_cnt_d  = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    key_d      = key_load ? asm_ins : key_q;
    deal_ptr_d = dispatch ? ptr_inc(deal_ptr_q) : deal_ptr_q;
  end

`ifdef KEY_ROTATION_EN
  logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;

  // Rotation counter: cleared by a key load, advances once per dispatched word.
  always_comb begin
    rot_cnt_d = rot_cnt_q;
    if (key_load) begin
      rot_cnt_d = '0;
    end else if (dispatch) begin
      rot_cnt_d = rot_cnt_q + 1'b1;
    end
  end

  // Rotation counter state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rot_cnt_q <= '0;
    end else begin
      rot_cnt_q <= rot_cnt_d;
    end
  end

  assign rot_sel = rot_cnt_q;
`else
  assign rot_sel = '0;
`endif

  // Lanes encrypt one cycle after load; the collector drains them in deal order.
  always_comb begin
    lane_full_d  = lane_full_q;
    lane_done_d  = lane_done_q;
    lane_word_d  = lane_word_q;
    lane_rot_d   = lane_rot_q;
    lane_bytes_d = lane_bytes_q;
    drain_ptr_d  = drain_ptr_q;
    coll_sr_d    = coll_sr_q;
    coll_left_d  = coll_left_q;

    for (int unsigned i = 0; i < NUM_ENC; i++) begin
      if (lane_full_q[i] && !lane_done_q[i]) begin
        lane_word_d[i] = lane_word_q[i] ^ rotl(key_q, lane_rot_q[i]);
        lane_done_d[i] = 1'b1;
      end
    end

    if (cap_fire) begin
      lane_full_d[drain_ptr_q] = 1'b0;
      lane_done_d[drain_ptr_q] = 1'b0;
      coll_sr_d   = lane_word_q[drain_ptr_q];
      coll_left_d = CntW'({lane_bytes_q[drain_ptr_q], 1'b0});
      drain_ptr_d = ptr_inc(drain_ptr_q);
    end else if ((coll_left_q != '0) && out_ready) begin
      coll_sr_d   = coll_sr_q << 4;
      coll_left_d = coll_left_q - 1'b1;
    end

    // Dispatch last so a lane captured this cycle is refilled.
    if (dispatch) begin
      lane_full_d[deal_ptr_q]  = 1'b1;
      lane_done_d[deal_ptr_q]  = 1'b0;
      lane_word_d[deal_ptr_q]  = disp_word;
      lane_rot_d[deal_ptr_q]   = rot_sel;
      lane_bytes_d[deal_ptr_q] = disp_bytes;
    end
  end

  // Output nibble is the top of the collector shift register.
  always_comb begin
    out_data    = coll_sr_q[WIDTH-1 -: 4];
    out_sending = (coll_left_q != '0);
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      asm_q       <= '0;
      nib_cnt_q   <= '0;
      key_q       <= '0;
      deal_ptr_q  <= '0;
      drain_ptr_q <= '0;
      coll_sr_q   <= '0;
      coll_left_q <= '0;
      for (int unsigned i = 0; i < NUM_ENC; i++) begin
        lane_full_q[i]  <= 1'b0;
        lane_done_q[i]  <= 1'b0;
        lane_word_q[i]  <= '0;
        lane_rot_q[i]   <= '0;
        lane_bytes_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      nib_cnt_q    <= nib_cnt_d;
      key_q        <= key_d;
      deal_ptr_q   <= deal_ptr_d;
      drain_ptr_q  <= drain_ptr_d;
      coll_sr_q    <= coll_sr_d;
      coll_left_q  <= coll_left_d;
      lane_full_q  <= lane_full_d;
      lane_done_q  <= lane_done_d;
      lane_word_q  <= lane_word_d;
      lane_rot_q   <= lane_rot_d;
      lane_bytes_q <= lane_bytes_d;
    end
  end

endmodule

// File: tb/tb_qspi_crypt_pipeline.sv
// Bench for qspi_crypt_pipeline: byte-level cipher model plus literal vectors.
module tb_qspi_crypt_pipeline;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_sending = 1'b0;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_sending;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  qspi_crypt_pipeline dut (
    .clk        (clk),
    .reset      (reset),
    .prog       (prog),
    .in_data    (in_data),
    .in_sending (in_sending),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sending(out_sending),
    .out_ready  (out_ready)
  );

`ifdef KEY_ROTATION_EN
  localparam bit RotEn = 1'b1;
`else
  localparam bit RotEn = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [31:0] key_m = 32'h0;
  int         widx = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_log[$];
  logic [7:0] byte_q[$];
  bit         prev_hold = 1'b0;
  logic [3:0] prev_data = 4'h0;
  bit         saw_stall = 1'b0;

  function automatic logic [31:0] rotl_m(input logic [31:0] k, input int r);
    logic [31:0] t;
    t = k;
    for (int i = 0; i < r; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  // Key byte j (0 = most significant) applied to word w since the last key load.
  function automatic logic [7:0] key_byte(input int w, input int j);
    logic [31:0] kr;
    kr = rotl_m(key_m, RotEn ? (w % 32) : 0);
    return kr[31-8*j -: 8];
  endfunction

  function automatic logic [31:0] log_word(input int s);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 8; i++) w = {w[27:0], got_log[s+i]};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Compare process: every accepted output nibble against the model queue, plus hold rule.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_hold) begin
        checks++;
        if (out_sending !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL hold got %b/%h expected 1/%h", out_sending, out_data, prev_data);
        end
      end
      if (out_sending && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_nibble got %h expected none", out_data);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL nibble got %h expected %h", out_data, e);
          end
        end
        got_log.push_back(out_data);
      end
      prev_hold = out_sending && !out_ready;
      prev_data = out_data;
      if (!out_ready && in_sending && !in_ready) saw_stall = 1'b1;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send_nibble(input logic [3:0] n);
    bit ok;
    in_data    = n;
    in_sending = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_burst();
    in_sending = 1'b0;
    in_data    = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic program_key(input logic [31:0] k);
    prog = 1'b1;
    @(posedge clk);
    #1;
    prog = 1'b0;
    for (int i = 0; i < 8; i++) send_nibble(k[31-4*i -: 4]);
    end_burst();
    key_m = k;
    widx  = 0;
  endtask

  // Model first, then drive: each burst starts a fresh word.
  task automatic send_bytes();
    int n;
    n = byte_q.size();
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = byte_q[i] ^ key_byte(widx + i / 4, i % 4);
      exp_q.push_back(e[7:4]);
      exp_q.push_back(e[3:0]);
    end
    widx += (n + 3) / 4;
    for (int i = 0; i < n; i++) begin
      send_nibble(byte_q[i][7:4]);
      send_nibble(byte_q[i][3:0]);
    end
    end_burst();
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_sending;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_sending", out_sending, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Key then "ABCD"
    program_key(32'hB4352B93);
    got_log.delete();
    byte_q = {8'h41, 8'h42, 8'h43, 8'h44};
    send_bytes();
    wait_drain("drain_abcd");
    check("abcd_count", got_log.size(), 8);
    check("abcd_word", log_word(0), 32'hF57768D7);

    // Continue with "EFGH"
    got_log.delete();
    byte_q = {8'h45, 8'h46, 8'h47, 8'h48};
    send_bytes();
    wait_drain("drain_efgh");
`ifdef KEY_ROTATION_EN
    check("efgh_word", log_word(0), 32'h2D2C106F);
`else
    check("efgh_word", log_word(0), 32'hF1736CDB);
`endif

    // Decrypt the ciphertext after reloading the same key
    program_key(32'hB4352B93);
    got_log.delete();
`ifdef KEY_ROTATION_EN
    byte_q = {8'hF5, 8'h77, 8'h68, 8'hD7, 8'h2D, 8'h2C, 8'h10, 8'h6F};
`else
    byte_q = {8'hF5, 8'h77, 8'h68, 8'hD7, 8'hF1, 8'h73, 8'h6C, 8'hDB};
`endif
    send_bytes();
    wait_drain("drain_decrypt");
    check("decrypt_w0", log_word(0), 32'h41424344);
    check("decrypt_w1", log_word(8), 32'h45464748);

    // 64-word stream with a 20-cycle sink stall
    got_log.delete();
    byte_q.delete();
    for (int i = 0; i < 256; i++) byte_q.push_back(8'((i * 7 + 3) & 8'hFF));
    saw_stall = 1'b0;
    fork
      send_bytes();
      begin
        repeat (60) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_stream");
    check("stream_count", got_log.size(), 512);
    check("stream_backpressure", saw_stall, 1);

    // Partial final word: "ABCDEF"
    program_key(32'hB4352B93);
    got_log.delete();
    byte_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    send_bytes();
    wait_drain("drain_partial");
    check("partial_count", got_log.size(), 12);
    check("partial_w0", log_word(0), 32'hF57768D7);
`ifdef KEY_ROTATION_EN
    check("partial_tail", {got_log[8], got_log[9], got_log[10], got_log[11]}, 16'h2D2C);
`else
    check("partial_tail", {got_log[8], got_log[9], got_log[10], got_log[11]}, 16'hF173);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
